// File: rtl/ifu_fetch.sv
// ifu_fetch: RV32I fetch stage; holds the PC, reads instruction memory over req/ack, hands words to control.
// Ports: CLK/RST (sync, active-high); PC_CLK/NEXT_PC advance request and target from control;
// IMEM_ADDR/IMEM_REQ/IMEM_ACK/IMEM_RDATA memory handshake; MEM_INST/INST_ENB/PC_ADDR instruction out;
// FETCH_BUSY/FETCH_FAULT/FAULT_CAUSE status. Optional request timeout via `define IFU_TIMEOUT_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PC_CLK,
  input  logic [31:0] NEXT_PC,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_REQ,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] MEM_INST,
  output logic        INST_ENB,
  output logic [31:0] PC_ADDR,
  output logic        FETCH_BUSY,
  output logic        FETCH_FAULT,
  output logic [1:0]  FAULT_CAUSE
);
  typedef enum logic [1:0] {REQ, HOLD, FAULT} state_t;
  state_t state, next_state;
  logic [31:0] pc;
  logic pc_clk_q, rise, ack, jump, misalign, timeout;
  assign IMEM_ADDR = pc;
  assign FETCH_BUSY = state == REQ;
`ifdef IFU_TIMEOUT_EN
  logic [15:0] cnt;
  // Count outstanding-request cycles; fault on the cycle that would make TIMEOUT_CYCLES of them.
  assign timeout = state == REQ && IMEM_REQ && !IMEM_ACK && cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLK)
    if (RST || !IMEM_REQ) cnt <= '0;
    else if (!IMEM_ACK) cnt <= cnt + 16'd1;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    rise = PC_CLK && !pc_clk_q;
    ack = state == REQ && IMEM_REQ && IMEM_ACK;
    jump = state == HOLD && rise && NEXT_PC[1:0] == 2'b00;
    misalign = state == HOLD && rise && NEXT_PC[1:0] != 2'b00;
    next_state = state == REQ ? (ack ? HOLD : timeout ? FAULT : REQ) :
                 state == HOLD ? (jump ? REQ : misalign ? FAULT : HOLD) : FAULT;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state <= REQ;
      pc <= RESET_PC & ~32'h3;
      PC_ADDR <= RESET_PC & ~32'h3;
      MEM_INST <= 32'h0000_0013;
      INST_ENB <= 1'b0;
      IMEM_REQ <= 1'b0;
      FETCH_FAULT <= 1'b0;
      FAULT_CAUSE <= 2'b00;
      pc_clk_q <= 1'b1;
    end else begin
      state <= next_state;
      pc_clk_q <= PC_CLK;
      INST_ENB <= ack;
      // REQ entered from reset has no request yet; raise it on the first free edge.
      IMEM_REQ <= (state == REQ && !ack && !timeout) || jump;
      if (ack) begin
        MEM_INST <= IMEM_RDATA;
        PC_ADDR <= pc;
      end
      if (jump) pc <= NEXT_PC;
      if (misalign || timeout) begin
        FETCH_FAULT <= 1'b1;
        FAULT_CAUSE <= misalign ? 2'b01 : 2'b10;
      end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized transaction-level bench for ifu_fetch
module tb_ifu_fetch;
  logic CLK = 0, RST = 1, PC_CLK = 1, IMEM_ACK = 0;
  logic [31:0] NEXT_PC = 0, IMEM_RDATA = 0;
  logic [31:0] IMEM_ADDR, MEM_INST, PC_ADDR;
  logic IMEM_REQ, INST_ENB, FETCH_BUSY, FETCH_FAULT;
  logic [1:0] FAULT_CAUSE;
  int total = 0, bad = 0;
  logic [31:0] m_pc, m_inst;
  ifu_fetch #(.RESET_PC(32'h100), .TIMEOUT_CYCLES(10)) dut (
    .CLK(CLK), .RST(RST), .PC_CLK(PC_CLK), .NEXT_PC(NEXT_PC), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .MEM_INST(MEM_INST),
    .INST_ENB(INST_ENB), .PC_ADDR(PC_ADDR), .FETCH_BUSY(FETCH_BUSY), .FETCH_FAULT(FETCH_FAULT),
    .FAULT_CAUSE(FAULT_CAUSE));
  always #5 CLK = ~CLK;
  task automatic step();
    @(negedge CLK);
  endtask
  task automatic apply_reset();
    RST = 1; PC_CLK = 1; IMEM_ACK = 0;
    repeat (3) step();
    RST = 0;
    m_pc = 32'h100; m_inst = 32'h13;
  endtask
  task automatic fetch(input logic [31:0] npc, input int wt, input logic [31:0] word, input bit noise);
    PC_CLK = 1; NEXT_PC = npc; step();
    PC_CLK = 0; NEXT_PC = $urandom;
    total++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== npc || INST_ENB !== 1'b0)
      begin bad++; $display("FAIL fetch_issue req=%b addr=%h enb=%b want 1/%h/0", IMEM_REQ, IMEM_ADDR, INST_ENB, npc); end
    for (int i = 0; i < wt; i++) begin
      if (noise) begin PC_CLK = 1'($urandom); NEXT_PC = $urandom; end
      step();
      total++; if (IMEM_REQ !== 1'b1 || FETCH_BUSY !== 1'b1 || IMEM_ADDR !== npc || INST_ENB !== 1'b0)
        begin bad++; $display("FAIL fetch_wait req=%b busy=%b addr=%h enb=%b want 1/1/%h/0", IMEM_REQ, FETCH_BUSY, IMEM_ADDR, INST_ENB, npc); end
    end
    PC_CLK = 0; IMEM_ACK = 1; IMEM_RDATA = word; step();
    IMEM_ACK = 0; IMEM_RDATA = $urandom;
    m_pc = npc; m_inst = word;
    total++; if (INST_ENB !== 1'b1 || MEM_INST !== m_inst || PC_ADDR !== m_pc || IMEM_REQ !== 1'b0 || FETCH_BUSY !== 1'b0)
      begin bad++; $display("FAIL fetch_ack enb=%b inst=%h pc=%h req=%b busy=%b want 1/%h/%h/0/0", INST_ENB, MEM_INST, PC_ADDR, IMEM_REQ, FETCH_BUSY, m_inst, m_pc); end
    step();
    total++; if (INST_ENB !== 1'b0 || MEM_INST !== m_inst || PC_ADDR !== m_pc)
      begin bad++; $display("FAIL fetch_pulse enb=%b inst=%h pc=%h want 0/%h/%h", INST_ENB, MEM_INST, PC_ADDR, m_inst, m_pc); end
  endtask
  task automatic test_reset();
    apply_reset();
    total++; if (IMEM_REQ !== 1'b0 || INST_ENB !== 1'b0 || MEM_INST !== 32'h13 || FETCH_FAULT !== 1'b0 || FAULT_CAUSE !== 2'b00 || IMEM_ADDR !== 32'h100)
      begin bad++; $display("FAIL reset_state req=%b enb=%b inst=%h flt=%b cause=%b addr=%h", IMEM_REQ, INST_ENB, MEM_INST, FETCH_FAULT, FAULT_CAUSE, IMEM_ADDR); end
    step();
    total++; if (IMEM_REQ !== 1'b1 || FETCH_BUSY !== 1'b1 || IMEM_ADDR !== 32'h100)
      begin bad++; $display("FAIL reset_first_req req=%b busy=%b addr=%h want 1/1/100", IMEM_REQ, FETCH_BUSY, IMEM_ADDR); end
    step();
    IMEM_ACK = 1; IMEM_RDATA = 32'h00500093; step(); IMEM_ACK = 0;
    total++; if (INST_ENB !== 1'b1 || MEM_INST !== 32'h00500093 || PC_ADDR !== 32'h100)
      begin bad++; $display("FAIL reset_fetch enb=%b inst=%h pc=%h want 1/00500093/100", INST_ENB, MEM_INST, PC_ADDR); end
    step();
    total++; if (INST_ENB !== 1'b0) begin bad++; $display("FAIL reset_pulse enb=%b want 0", INST_ENB); end
    repeat (3) step();
    total++; if (IMEM_REQ !== 1'b0 || FETCH_BUSY !== 1'b0 || IMEM_ADDR !== 32'h100)
      begin bad++; $display("FAIL reset_no_advance req=%b busy=%b addr=%h want 0/0/100", IMEM_REQ, FETCH_BUSY, IMEM_ADDR); end
    PC_CLK = 0; step();
    m_pc = 32'h100; m_inst = 32'h00500093;
  endtask
  task automatic test_sequential();
    fetch(32'h104, 0, 32'h00a00113, 1'b0);
  endtask
  task automatic test_wait_states();
    fetch(32'h108, 5, 32'h002081b3, 1'b0);
  endtask
  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      fetch($urandom & ~32'h3, int'($urandom_range(0, 4)), $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask
  task automatic test_misaligned();
    logic [31:0] bad_pc;
    bad_pc = 32'h202;
    PC_CLK = 1; NEXT_PC = bad_pc; step(); PC_CLK = 0;
    total++; if (FETCH_FAULT !== 1'b1 || FAULT_CAUSE !== 2'b01 || IMEM_REQ !== 1'b0 || IMEM_ADDR !== m_pc || MEM_INST !== m_inst || INST_ENB !== 1'b0)
      begin bad++; $display("FAIL misalign flt=%b cause=%b req=%b addr=%h inst=%h enb=%b want 1/01/0/%h/%h/0", FETCH_FAULT, FAULT_CAUSE, IMEM_REQ, IMEM_ADDR, MEM_INST, INST_ENB, m_pc, m_inst); end
    for (int n = 0; n < 6; n++) begin
      PC_CLK = 1; NEXT_PC = $urandom & ~32'h3; IMEM_ACK = 1'($urandom); IMEM_RDATA = $urandom; step();
      PC_CLK = 0; IMEM_ACK = 0; step();
      total++; if (FETCH_FAULT !== 1'b1 || FAULT_CAUSE !== 2'b01 || IMEM_REQ !== 1'b0 || IMEM_ADDR !== m_pc || MEM_INST !== m_inst || INST_ENB !== 1'b0)
        begin bad++; $display("FAIL fault_sticky flt=%b cause=%b req=%b addr=%h inst=%h enb=%b", FETCH_FAULT, FAULT_CAUSE, IMEM_REQ, IMEM_ADDR, MEM_INST, INST_ENB); end
    end
  endtask
  task automatic test_reset_mid();
    apply_reset();
    step();
    RST = 1; IMEM_ACK = 1; IMEM_RDATA = 32'hdeadbeef; step();
    total++; if (IMEM_REQ !== 1'b0 || MEM_INST !== 32'h13 || INST_ENB !== 1'b0 || FETCH_FAULT !== 1'b0 || IMEM_ADDR !== 32'h100)
      begin bad++; $display("FAIL reset_mid req=%b inst=%h enb=%b flt=%b addr=%h want 0/13/0/0/100", IMEM_REQ, MEM_INST, INST_ENB, FETCH_FAULT, IMEM_ADDR); end
    RST = 0; IMEM_ACK = 0; PC_CLK = 0; step();
    total++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h100)
      begin bad++; $display("FAIL reset_restart req=%b addr=%h want 1/100", IMEM_REQ, IMEM_ADDR); end
    IMEM_ACK = 1; IMEM_RDATA = 32'h00000093; step(); IMEM_ACK = 0;
    total++; if (INST_ENB !== 1'b1 || MEM_INST !== 32'h00000093 || PC_ADDR !== 32'h100)
      begin bad++; $display("FAIL reset_refetch enb=%b inst=%h pc=%h want 1/00000093/100", INST_ENB, MEM_INST, PC_ADDR); end
    step();
    m_pc = 32'h100; m_inst = 32'h00000093;
  endtask
  task automatic test_timeout();
    PC_CLK = 1; NEXT_PC = 32'h300; step(); PC_CLK = 0;
`ifdef IFU_TIMEOUT_EN
    for (int i = 1; i < 10; i++) begin
      step();
      total++; if (IMEM_REQ !== 1'b1 || FETCH_FAULT !== 1'b0)
        begin bad++; $display("FAIL timeout_early cycle=%0d req=%b flt=%b want 1/0", i, IMEM_REQ, FETCH_FAULT); end
    end
    step();
    total++; if (IMEM_REQ !== 1'b0 || FETCH_FAULT !== 1'b1 || FAULT_CAUSE !== 2'b10 || FETCH_BUSY !== 1'b0)
      begin bad++; $display("FAIL timeout req=%b flt=%b cause=%b busy=%b want 0/1/10/0", IMEM_REQ, FETCH_FAULT, FAULT_CAUSE, FETCH_BUSY); end
`else
    repeat (300) step();
    total++; if (IMEM_REQ !== 1'b1 || FETCH_FAULT !== 1'b0 || FAULT_CAUSE !== 2'b00 || IMEM_ADDR !== 32'h300)
      begin bad++; $display("FAIL no_timeout req=%b flt=%b cause=%b addr=%h want 1/0/00/300", IMEM_REQ, FETCH_FAULT, FAULT_CAUSE, IMEM_ADDR); end
`endif
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_random();
    test_misaligned();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
